// File: rtl/dpram_burst_ctrl.sv
// dpram_burst_ctrl
// Burst read/write controller sitting between a user command source and a
// simple dual-port RAM. One command is served at a time. A burst is Len+1
// words starting at A, and the address wraps modulo the RAM depth. Writes hand
// each word over with a DIn_Ack pulse. Reads wait RD_LAT edges for the RAM and
// then capture Q into DOut with a one-cycle DOut_Valid pulse.
// All outputs are registered. Reset is synchronous and active-high on 'ar'.

module dpram_burst_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int LEN_W  = 4,
    parameter int RD_LAT = 3
) (
    input  logic              clk,
    input  logic              ar,
    input  logic              RD,
    input  logic              WR,
    input  logic [ADDR_W-1:0] A,
    input  logic [LEN_W-1:0]  Len,
    input  logic [DATA_W-1:0] DIn,
    input  logic [DATA_W-1:0] Q,
    output logic [DATA_W-1:0] Data,
    output logic [ADDR_W-1:0] Wr_A,
    output logic              WE,
    output logic [ADDR_W-1:0] Rd_A,
    output logic [DATA_W-1:0] DOut,
    output logic              DOut_Valid,
    output logic              DIn_Ack,
    output logic              Busy,
    output logic              Done
);

    // The wait counter is 4 bits wide, so the RAM latency must fit in 1..15.
    if (RD_LAT < 1 || RD_LAT > 15) begin : g_bad_rd_lat
        $error("dpram_burst_ctrl: RD_LAT must be within 1..15");
    end

    // Value of the wait counter on the last RD_WAIT edge.
    localparam logic [3:0] LAT_LAST = 4'(RD_LAT - 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WR_LOAD   = 3'd1,
        WR_STROBE = 3'd2,
        RD_ISSUE  = 3'd3,
        RD_WAIT   = 3'd4,
        RD_CAP    = 3'd5,
        FINISH    = 3'd6
    } state_t;

    state_t state;
    state_t state_nxt;

    // Working burst address, beats still to go after the current one,
    // and the RAM latency counter.
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  rem;
    logic [3:0]        delay;

    logic [ADDR_W-1:0] addr_nxt;
    logic [LEN_W-1:0]  rem_nxt;
    logic [3:0]        delay_nxt;

    logic [DATA_W-1:0] data_nxt;
    logic [ADDR_W-1:0] wr_a_nxt;
    logic              we_nxt;
    logic [ADDR_W-1:0] rd_a_nxt;
    logic [DATA_W-1:0] dout_nxt;
    logic              dout_valid_nxt;
    logic              din_ack_nxt;
    logic              busy_nxt;
    logic              done_nxt;

    // State and every registered output. Reset clears everything at once,
    // which also aborts a burst in flight with no Done pulse.
    always_ff @(posedge clk) begin
        if (ar) begin
            state      <= IDLE;
            addr       <= '0;
            rem        <= '0;
            delay      <= '0;
            Data       <= '0;
            Wr_A       <= '0;
            WE         <= 1'b0;
            Rd_A       <= '0;
            DOut       <= '0;
            DOut_Valid <= 1'b0;
            DIn_Ack    <= 1'b0;
            Busy       <= 1'b0;
            Done       <= 1'b0;
        end else begin
            state      <= state_nxt;
            addr       <= addr_nxt;
            rem        <= rem_nxt;
            delay      <= delay_nxt;
            Data       <= data_nxt;
            Wr_A       <= wr_a_nxt;
            WE         <= we_nxt;
            Rd_A       <= rd_a_nxt;
            DOut       <= dout_nxt;
            DOut_Valid <= dout_valid_nxt;
            DIn_Ack    <= din_ack_nxt;
            Busy       <= busy_nxt;
            Done       <= done_nxt;
        end
    end

    // Next-state decision: reads win over writes, and commands are only
    // looked at in IDLE so anything arriving mid-burst is dropped.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (RD) begin
                    state_nxt = RD_ISSUE;
                end else if (WR) begin
                    state_nxt = WR_LOAD;
                end
            end
            WR_LOAD:   state_nxt = WR_STROBE;
            WR_STROBE: state_nxt = (rem != '0) ? WR_LOAD : FINISH;
            RD_ISSUE:  state_nxt = RD_WAIT;
            RD_WAIT: begin
                if (delay == LAT_LAST) begin
                    state_nxt = RD_CAP;
                end
            end
            RD_CAP:    state_nxt = (rem != '0) ? RD_ISSUE : FINISH;
            FINISH:    state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    // Next values of the datapath registers and outputs; anything not
    // mentioned for a state simply holds its value.
    always_comb begin
        addr_nxt       = addr;
        rem_nxt        = rem;
        delay_nxt      = delay;
        data_nxt       = Data;
        wr_a_nxt       = Wr_A;
        we_nxt         = WE;
        rd_a_nxt       = Rd_A;
        dout_nxt       = DOut;
        dout_valid_nxt = DOut_Valid;
        din_ack_nxt    = DIn_Ack;
        busy_nxt       = Busy;
        done_nxt       = Done;
        case (state)
            IDLE: begin
                done_nxt       = 1'b0;
                dout_valid_nxt = 1'b0;
                if (RD || WR) begin
                    addr_nxt = A;
                    rem_nxt  = Len;
                    busy_nxt = 1'b1;
                end
            end
            WR_LOAD: begin
                data_nxt    = DIn;
                wr_a_nxt    = addr;
                we_nxt      = 1'b0;
                din_ack_nxt = 1'b1;
            end
            WR_STROBE: begin
                we_nxt      = 1'b1;
                din_ack_nxt = 1'b0;
                addr_nxt    = addr + ADDR_W'(1);
                if (rem != '0) begin
                    rem_nxt = rem - LEN_W'(1);
                end
            end
            RD_ISSUE: begin
                rd_a_nxt       = addr;
                delay_nxt      = '0;
                dout_valid_nxt = 1'b0;
            end
            RD_WAIT: begin
                delay_nxt = delay + 4'd1;
            end
            RD_CAP: begin
                dout_nxt       = Q;
                dout_valid_nxt = 1'b1;
                addr_nxt       = addr + ADDR_W'(1);
                if (rem != '0) begin
                    rem_nxt = rem - LEN_W'(1);
                end
            end
            FINISH: begin
                we_nxt         = 1'b0;
                dout_valid_nxt = 1'b0;
                done_nxt       = 1'b1;
                busy_nxt       = 1'b0;
            end
            default: begin
                we_nxt         = 1'b0;
                din_ack_nxt    = 1'b0;
                dout_valid_nxt = 1'b0;
                done_nxt       = 1'b0;
                busy_nxt       = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_dpram_burst_ctrl.sv
// tb_dpram_burst_ctrl
// Three controllers (RD_LAT = 3, 1, 15) each drive their own RAM model with a
// fixed read pipeline. A directed vector table, a reset-abort sequence and
// random bursts are checked against a word-level memory model and timing
// derived from the burst length and read latency.

module tb_dpram_burst_ctrl;

    localparam int DATA_W    = 16;
    localparam int ADDR_W    = 10;
    localparam int LEN_W     = 4;
    localparam int DEPTH     = 1 << ADDR_W;
    localparam int NINST     = 3;
    localparam int MAX_EDGES = 400;
    localparam int NVEC      = 14;
    localparam int NRAND     = 30;

    logic clk = 1'b0;
    logic ar;
    logic ram_clr;

    logic              rd         [NINST];
    logic              wr         [NINST];
    logic [ADDR_W-1:0] a          [NINST];
    logic [LEN_W-1:0]  len        [NINST];
    logic [DATA_W-1:0] din        [NINST];
    logic [DATA_W-1:0] data       [NINST];
    logic [ADDR_W-1:0] wr_a       [NINST];
    logic              we         [NINST];
    logic [ADDR_W-1:0] rd_a       [NINST];
    logic [DATA_W-1:0] dout       [NINST];
    logic              dout_valid [NINST];
    logic              din_ack    [NINST];
    logic              busy       [NINST];
    logic              done       [NINST];

    // Word-level picture of each RAM as the bench believes it should be.
    logic [DATA_W-1:0] model_mem [NINST][DEPTH];

    // Observations of one transaction.
    int obs_we_addr[$];
    int obs_we_data[$];
    int obs_rd_addr[$];
    int obs_rd_data[$];
    int obs_rd_edge[$];
    int obs_done_cnt;
    int obs_done_edge;
    int obs_busy_err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int                g;
        bit                r;
        bit                w;
        logic [ADDR_W-1:0] a;
        logic [LEN_W-1:0]  l;
        logic [DATA_W-1:0] dbase;
        logic [DATA_W-1:0] dstep;
        int                inject;
        int                exp_done;
        int                exp_we;
        int                exp_valid;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic int lat_of(input int g);
        case (g)
            0:       return 3;
            1:       return 1;
            default: return 15;
        endcase
    endfunction

    // 100 MHz-style free-running clock.
    always #5 clk = ~clk;

    for (genvar g = 0; g < NINST; g++) begin : inst
        localparam int LAT = (g == 0) ? 3 : (g == 1) ? 1 : 15;
        logic [DATA_W-1:0] mem  [DEPTH];
        logic [DATA_W-1:0] pipe [16];

        // RAM model: write port plus a read pipeline exactly LAT edges deep.
        always @(posedge clk) begin
            if (ram_clr) begin
                for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            end else if (we[g]) begin
                mem[wr_a[g]] <= data[g];
            end
            pipe[0] <= mem[rd_a[g]];
            for (int k = 1; k < 16; k++) pipe[k] <= pipe[k-1];
        end

        dpram_burst_ctrl #(
            .DATA_W(DATA_W),
            .ADDR_W(ADDR_W),
            .LEN_W (LEN_W),
            .RD_LAT(LAT)
        ) dut (
            .clk       (clk),
            .ar        (ar),
            .RD        (rd[g]),
            .WR        (wr[g]),
            .A         (a[g]),
            .Len       (len[g]),
            .DIn       (din[g]),
            .Q         (pipe[LAT-1]),
            .Data      (data[g]),
            .Wr_A      (wr_a[g]),
            .WE        (we[g]),
            .Rd_A      (rd_a[g]),
            .DOut      (dout[g]),
            .DOut_Valid(dout_valid[g]),
            .DIn_Ack   (din_ack[g]),
            .Busy      (busy[g]),
            .Done      (done[g])
        );
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic checkReset(input int g);
        checkOutput("rst_data",       int'(data[g]),       0);
        checkOutput("rst_wr_a",       int'(wr_a[g]),       0);
        checkOutput("rst_we",         int'(we[g]),         0);
        checkOutput("rst_rd_a",       int'(rd_a[g]),       0);
        checkOutput("rst_dout",       int'(dout[g]),       0);
        checkOutput("rst_dout_valid", int'(dout_valid[g]), 0);
        checkOutput("rst_din_ack",    int'(din_ack[g]),    0);
        checkOutput("rst_busy",       int'(busy[g]),       0);
        checkOutput("rst_done",       int'(done[g]),       0);
    endtask

    // Issue one command at a negedge, feed write words on DIn_Ack, optionally
    // pulse WR again at edge 'inject', and log what the controller does.
    task automatic applyStimulus(input int g, input bit r, input bit w,
                                 input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] l,
                                 input logic [DATA_W-1:0] dbase, input logic [DATA_W-1:0] dstep,
                                 input int inject);
        int beat = 0;
        bit seen = 1'b0;
        obs_we_addr.delete();
        obs_we_data.delete();
        obs_rd_addr.delete();
        obs_rd_data.delete();
        obs_rd_edge.delete();
        obs_done_cnt  = 0;
        obs_done_edge = -1;
        obs_busy_err  = 0;
        rd[g]  = r;
        wr[g]  = w;
        a[g]   = addr;
        len[g] = l;
        din[g] = dbase;
        for (int e = 0; e < MAX_EDGES; e++) begin
            if (e == inject && e > 0) begin
                wr[g] = 1'b1;
                a[g]  = 10'h2AA;
            end
            @(posedge clk);
            @(negedge clk);
            rd[g] = 1'b0;
            wr[g] = 1'b0;
            if (din_ack[g]) begin
                beat++;
                din[g] = dbase + 16'(beat) * dstep;
            end
            if (we[g]) begin
                obs_we_addr.push_back(int'(wr_a[g]));
                obs_we_data.push_back(int'(data[g]));
            end
            if (dout_valid[g]) begin
                obs_rd_addr.push_back(int'(rd_a[g]));
                obs_rd_data.push_back(int'(dout[g]));
                obs_rd_edge.push_back(e);
            end
            if (done[g]) begin
                obs_done_cnt++;
                if (!seen) obs_done_edge = e;
                seen = 1'b1;
            end
            if (busy[g] != !seen) obs_busy_err++;
            if (seen && e >= obs_done_edge + 3) break;
        end
    endtask

    // Compare a logged transaction against the memory model and the burst
    // timing, then fold any write into the model.
    task automatic checkTransaction(input int g, input bit r, input bit w,
                                    input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] l,
                                    input logic [DATA_W-1:0] dbase, input logic [DATA_W-1:0] dstep,
                                    input int exp_done, input int exp_we, input int exp_valid);
        int lat   = lat_of(g);
        int beats = int'(l) + 1;
        int n;
        int ad;
        logic [DATA_W-1:0] word;
        checkOutput("done_count",  obs_done_cnt,  1);
        checkOutput("done_edge",   obs_done_edge, exp_done);
        checkOutput("busy_errors", obs_busy_err,  0);
        checkOutput("we_pulses",   obs_we_addr.size(), exp_we);
        checkOutput("valid_pulses", obs_rd_data.size(), exp_valid);
        if (r) begin
            n = (obs_rd_data.size() < beats) ? obs_rd_data.size() : beats;
            for (int i = 0; i < n; i++) begin
                ad = (int'(addr) + i) % DEPTH;
                checkOutput("rd_addr", obs_rd_addr[i], ad);
                checkOutput("rd_data", obs_rd_data[i], int'(model_mem[g][ad]));
                checkOutput("rd_edge", obs_rd_edge[i], (i + 1) * (lat + 2));
            end
            ad = (int'(addr) + beats - 1) % DEPTH;
            checkOutput("dout_hold", int'(dout[g]), int'(model_mem[g][ad]));
        end else if (w) begin
            n = (obs_we_addr.size() < beats) ? obs_we_addr.size() : beats;
            for (int i = 0; i < n; i++) begin
                word = dbase + 16'(i) * dstep;
                checkOutput("wr_addr", obs_we_addr[i], (int'(addr) + i) % DEPTH);
                checkOutput("wr_data", obs_we_data[i], int'(word));
            end
            for (int i = 0; i < beats; i++) begin
                word = dbase + 16'(i) * dstep;
                model_mem[g][(int'(addr) + i) % DEPTH] = word;
            end
        end
    endtask

    // Bound the whole run in case the design locks up.
    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int seen;
        int dcount;
        int wcount;
        int bcount;

        // g, r, w, a, len, dbase, dstep, inject, done edge, WE pulses, valid pulses
        vecs[0]  = '{0, 1'b0, 1'b1, 10'h005, 4'd0,  16'hBEEF, 16'h0000, -1,  3,  1,  0};
        vecs[1]  = '{0, 1'b1, 1'b0, 10'h005, 4'd0,  16'h0000, 16'h0000, -1,  6,  0,  1};
        vecs[2]  = '{0, 1'b0, 1'b1, 10'h3FE, 4'd3,  16'h1111, 16'h1111, -1,  9,  4,  0};
        vecs[3]  = '{0, 1'b1, 1'b0, 10'h3FE, 4'd3,  16'h0000, 16'h0000, -1, 21,  0,  4};
        vecs[4]  = '{0, 1'b1, 1'b1, 10'h3FF, 4'd0,  16'hDEAD, 16'h0000, -1,  6,  0,  1};
        vecs[5]  = '{0, 1'b1, 1'b0, 10'h000, 4'd1,  16'h0000, 16'h0000,  3, 11,  0,  2};
        vecs[6]  = '{0, 1'b1, 1'b0, 10'h001, 4'd0,  16'h0000, 16'h0000,  6,  6,  0,  1};
        vecs[7]  = '{0, 1'b0, 1'b1, 10'h100, 4'd15, 16'h0A00, 16'h0003, -1, 33, 16,  0};
        vecs[8]  = '{0, 1'b1, 1'b0, 10'h100, 4'd15, 16'h0000, 16'h0000, -1, 81,  0, 16};
        vecs[9]  = '{1, 1'b0, 1'b1, 10'h3FE, 4'd3,  16'h5000, 16'h0007, -1,  9,  4,  0};
        vecs[10] = '{1, 1'b1, 1'b0, 10'h3FE, 4'd3,  16'h0000, 16'h0000, -1, 13,  0,  4};
        vecs[11] = '{2, 1'b0, 1'b1, 10'h200, 4'd1,  16'h7000, 16'h0001, -1,  5,  2,  0};
        vecs[12] = '{2, 1'b1, 1'b0, 10'h200, 4'd1,  16'h0000, 16'h0000, -1, 35,  0,  2};
        vecs[13] = '{0, 1'b0, 1'b1, 10'h010, 4'd2,  16'h1234, 16'h0010,  2,  7,  3,  0};

        ar      = 1'b1;
        ram_clr = 1'b1;
        for (int g = 0; g < NINST; g++) begin
            rd[g]  = 1'b0;
            wr[g]  = 1'b0;
            a[g]   = '0;
            len[g] = '0;
            din[g] = '0;
            for (int i = 0; i < DEPTH; i++) model_mem[g][i] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        ram_clr = 1'b0;
        for (int g = 0; g < NINST; g++) checkReset(g);
        ar = 1'b0;
        @(negedge clk);

        $display("[TB] directed vectors");
        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].g, vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].l,
                          vecs[i].dbase, vecs[i].dstep, vecs[i].inject);
            checkTransaction(vecs[i].g, vecs[i].r, vecs[i].w, vecs[i].a, vecs[i].l,
                             vecs[i].dbase, vecs[i].dstep,
                             vecs[i].exp_done, vecs[i].exp_we, vecs[i].exp_valid);
        end

        $display("[TB] reset during a write burst");
        wr[0]  = 1'b1;
        a[0]   = 10'h050;
        len[0] = 4'd3;
        din[0] = 16'hA5A5;
        @(posedge clk);
        @(negedge clk);
        wr[0] = 1'b0;
        seen  = 0;
        for (int k = 0; k < 10 && seen == 0; k++) begin
            if (we[0]) begin
                seen = 1;
            end else begin
                @(posedge clk);
                @(negedge clk);
            end
        end
        checkOutput("abort_we_seen", seen, 1);
        ar = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ar = 1'b0;
        checkReset(0);
        dcount = 0;
        wcount = 0;
        bcount = 0;
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            dcount += int'(done[0]);
            wcount += int'(we[0]);
            bcount += int'(busy[0]);
        end
        checkOutput("abort_done_pulses", dcount, 0);
        checkOutput("abort_we_pulses",   wcount, 0);
        checkOutput("abort_busy_cycles", bcount, 0);
        // WE was high going into the reset edge, so that first word landed.
        model_mem[0][10'h050] = 16'hA5A5;

        $display("[TB] random bursts");
        for (int n = 0; n < NRAND; n++) begin
            int g;
            int kind;
            bit r;
            bit w;
            logic [ADDR_W-1:0] ra;
            logic [LEN_W-1:0]  rl;
            logic [DATA_W-1:0] rb;
            logic [DATA_W-1:0] rs;
            int beats;
            int lat;
            int exp_done;
            int inj;
            g    = int'($urandom_range(0, NINST - 1));
            kind = int'($urandom_range(0, 3));
            r    = (kind == 1 || kind == 2);
            w    = (kind != 1);
            ra   = ADDR_W'($urandom);
            rl   = (g == 2) ? LEN_W'($urandom_range(0, 3)) : LEN_W'($urandom);
            rb   = DATA_W'($urandom);
            rs   = DATA_W'($urandom);
            beats    = int'(rl) + 1;
            lat      = lat_of(g);
            exp_done = r ? beats * (lat + 2) + 1 : 2 * beats + 1;
            inj      = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, exp_done)) : -1;
            applyStimulus(g, r, w, ra, rl, rb, rs, inj);
            checkTransaction(g, r, w, ra, rl, rb, rs, exp_done,
                             (!r && w) ? beats : 0, r ? beats : 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dpram_burst_ctrl.md
Name: dpram_burst_ctrl

Overview:
- Parametrised successor to the single-word dual-port RAM controller.
- Serves one read or one write command at a time, at a configurable data width, address width and RAM read latency.
- Adds burst transfers of 1..2^LEN_W words with address auto-increment and wrap-around, plus per-word data handshakes and a Busy flag.
- Sits between a user-side command source and one simple dual-port RAM (separate write and read address ports, one write-enable).

Parameters:
- DATA_W, 16, data word width.
- ADDR_W, 10, RAM address width; depth = 2^ADDR_W.
- LEN_W, 4, burst length field width; beats = Len+1.
- RD_LAT, 3, edges from a Rd_A update until Q is valid; legal range 1..15.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- ar  in  1  reset, synchronous, active-high.
- RD  in  1  read command; sampled only in IDLE.
- WR  in  1  write command; sampled only in IDLE.
- A  in  ADDR_W  burst start address; sampled with the command.
- Len  in  LEN_W  burst length minus one; sampled with the command.
- DIn  in  DATA_W  write data; sampled in WR_LOAD.
- Q  in  DATA_W  RAM read data.
- Data  out  DATA_W  RAM write data.
- Wr_A  out  ADDR_W  RAM write address.
- WE  out  1  RAM write enable.
- Rd_A  out  ADDR_W  RAM read address.
- DOut  out  DATA_W  captured read word.
- DOut_Valid  out  1  one-cycle pulse per captured read word.
- DIn_Ack  out  1  one-cycle pulse; DIn was consumed this edge, so the source presents the next word before the next WR_LOAD.
- Busy  out  1  high while a command is in progress.
- Done  out  1  one-cycle pulse at the end of the burst.

Behaviour:
- All outputs are registered.
- Reset: when ar=1 at an edge, state goes to IDLE and every output goes to 0 (Data, Wr_A, WE, Rd_A, DOut, DOut_Valid, DIn_Ack, Busy, Done). Internal address register, beat counter and delay counter also clear.
- Reset mid-burst aborts the burst at that edge: WE drops, no Done pulse, and remaining beats are discarded.
- Internal registers: addr (ADDR_W), rem (LEN_W), delay (4 bits).
- Each edge performs the actions of the state the block is in at that edge.
- IDLE:
  - Done<=0, DOut_Valid<=0.
  - If RD=1: addr<=A, rem<=Len, Busy<=1, go to RD_ISSUE.
  - Else if WR=1: same latches, go to WR_LOAD.
  - RD has priority when RD and WR are both high. Commands arriving outside IDLE are ignored (no queueing).
- WR_LOAD: Data<=DIn, Wr_A<=addr, WE<=0, DIn_Ack<=1; go to WR_STROBE.
- WR_STROBE:
  - WE<=1, DIn_Ack<=0, addr<=addr+1, computed mod 2^ADDR_W (wraps from 2^ADDR_W-1 to 0).
  - If rem!=0: rem<=rem-1, go to WR_LOAD. Otherwise go to FINISH.
  - WE is high for exactly one cycle per beat, with Data and Wr_A stable throughout.
  - A write beat takes 2 cycles.
- RD_ISSUE: Rd_A<=addr, delay<=0, DOut_Valid<=0; go to RD_WAIT.
- RD_WAIT: delay<=delay+1; when delay==RD_LAT-1, go to RD_CAP. RD_WAIT lasts exactly RD_LAT edges.
- RD_CAP:
  - DOut<=Q, DOut_Valid<=1, addr<=addr+1 (wraps).
  - If rem!=0: rem<=rem-1, go to RD_ISSUE. Otherwise go to FINISH.
  - Q is therefore sampled RD_LAT+1 edges after the Rd_A update.
  - A read beat takes RD_LAT+2 cycles.
- FINISH: WE<=0, DOut_Valid<=0, Done<=1, Busy<=0; go to IDLE.
  - Done is high for the single cycle after this edge.
  - A new command can be accepted at the next edge, which clears Done.
- Undefined state encodings go to IDLE with all strobes (WE, DIn_Ack, DOut_Valid, Done) cleared.
- DOut holds its last captured value until the next capture or reset.
- Data, Wr_A and Rd_A hold their last values between commands.

Test Plan:
- Reset: drive ar=1 during a write burst while WE=1 -> next edge all outputs are 0, state is IDLE, and no Done pulse follows.
- Single write: WR=1, A=0x005, Len=0, DIn=0xBEEF at edge0 -> edge1 Data=0xBEEF, Wr_A=0x005, DIn_Ack=1; edge2 WE=1; edge3 WE=0, Done=1, Busy=0; edge4 Done=0.
- Single read: RD_LAT=3, RD=1, A=0x005, RAM holds 0xBEEF -> edge1 Rd_A=0x005; edge5 DOut=0xBEEF, DOut_Valid=1; edge6 Done=1.
- Burst with wrap-around:
  - Write burst WR=1, A=0x3FE, Len=3, DIn=0x1111/2222/3333/4444 advanced on each DIn_Ack -> four WE pulses at Wr_A=0x3FE, 0x3FF, 0x000, 0x001; single Done after the last beat.
  - Read burst of the same region -> four DOut_Valid pulses with DOut 0x1111, 0x2222, 0x3333, 0x4444, spaced 5 cycles apart.
- Command contention:
  - RD=1 and WR=1 together in IDLE -> read is performed, no WE pulse.
  - Pulse WR while Busy=1 -> ignored; no extra beats, Done count is unchanged.
- Latency sweep: RD_LAT=1 and RD_LAT=15 -> DOut_Valid occurs exactly RD_LAT+1 edges after Rd_A changes, and the sampled Q matches the RAM model.
